// File: rtl/line_rd_ctrl_pkg.sv
// Shared types and sizing helpers for the line-buffer read controller.
package line_rd_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_POP  = 2'd1,
        ST_READ = 2'd2
    } rd_state_e;

    // Width of an index/counter covering n states; never narrower than 1 bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Read cycles allowed before a line is declared stuck.
    function automatic int unsigned wd_limit(input int unsigned max_line,
                                             input int unsigned px_per_clk,
                                             input int unsigned slack);
        return (max_line + px_per_clk - 1) / px_per_clk + slack;
    endfunction

    localparam int unsigned WD_LIMIT_DFLT = wd_limit(1936, 4, 8);

endpackage

// File: rtl/line_rd_ctrl_if.sv
// Buffer-side and stream-side signal bundle for line_rd_ctrl.
interface line_rd_ctrl_if #(
    parameter int unsigned PX_WIDTH   = 12,
    parameter int unsigned PX_PER_CLK = 4,
    parameter int unsigned BUF_CNT    = 2,
    parameter int unsigned MAX_LINES  = 1096
);
    import line_rd_pkg::*;

    localparam int unsigned SEL_W = width_of(BUF_CNT);
    localparam int unsigned CNT_W = width_of(MAX_LINES + 1);

    logic                                              line_ready_i;
    logic [BUF_CNT-1:0]                                buf_empty_i;
    logic [BUF_CNT-1:0]                                buf_unread_i;
    logic [BUF_CNT-1:0][PX_PER_CLK-1:0][PX_WIDTH-1:0] buf_px_data_i;
    logic [BUF_CNT-1:0][PX_PER_CLK-1:0]                buf_px_data_val_i;
    logic [BUF_CNT-1:0]                                buf_line_end_i;
    logic [BUF_CNT-1:0]                                buf_frame_start_i;
    logic [BUF_CNT-1:0]                                buf_frame_end_i;

    logic [BUF_CNT-1:0]                                pop_line_o;
    logic [PX_PER_CLK-1:0][PX_WIDTH-1:0]               px_data_o;
    logic [PX_PER_CLK-1:0]                             px_data_val_o;
    logic                                              line_start_o;
    logic                                              line_end_o;
    logic                                              frame_start_o;
    logic                                              frame_end_o;
    logic [SEL_W-1:0]                                  rd_sel_o;
    logic [CNT_W-1:0]                                  line_cnt_o;
    logic                                              timeout_o;

    modport slave (
        input  line_ready_i, buf_empty_i, buf_unread_i, buf_px_data_i,
               buf_px_data_val_i, buf_line_end_i, buf_frame_start_i, buf_frame_end_i,
        output pop_line_o, px_data_o, px_data_val_o, line_start_o, line_end_o,
               frame_start_o, frame_end_o, rd_sel_o, line_cnt_o, timeout_o
    );

    modport master (
        output line_ready_i, buf_empty_i, buf_unread_i, buf_px_data_i,
               buf_px_data_val_i, buf_line_end_i, buf_frame_start_i, buf_frame_end_i,
        input  pop_line_o, px_data_o, px_data_val_o, line_start_o, line_end_o,
               frame_start_o, frame_end_o, rd_sel_o, line_cnt_o, timeout_o
    );

endinterface

// File: rtl/line_rd_ctrl_mux.sv
// Registered BUF_CNT:1 mux of the pixel/valid/framing bundle; zero outside the read window.
module line_rd_mux
    import line_rd_pkg::*;
#(
    parameter int unsigned PX_WIDTH   = 12,
    parameter int unsigned PX_PER_CLK = 4,
    parameter int unsigned BUF_CNT    = 2
) (
    input  logic                                              clk_i,
    input  logic                                              rst_n_i,
    input  logic                                              i_en,
    input  logic [width_of(BUF_CNT)-1:0]                      i_sel,
    input  logic [BUF_CNT-1:0][PX_PER_CLK-1:0][PX_WIDTH-1:0] i_px_data,
    input  logic [BUF_CNT-1:0][PX_PER_CLK-1:0]                i_px_val,
    input  logic [BUF_CNT-1:0]                                i_line_end,
    input  logic [BUF_CNT-1:0]                                i_frame_start,
    input  logic [BUF_CNT-1:0]                                i_frame_end,
    output logic [PX_PER_CLK-1:0][PX_WIDTH-1:0]               o_px_data,
    output logic [PX_PER_CLK-1:0]                             o_px_val,
    output logic                                              o_line_end,
    output logic                                              o_frame_start,
    output logic                                              o_frame_end
);

    logic [PX_PER_CLK-1:0][PX_WIDTH-1:0] r_px_data;
    logic [PX_PER_CLK-1:0]               r_px_val;
    logic                                r_line_end;
    logic                                r_frame_start;
    logic                                r_frame_end;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_px_data     <= '0;
            r_px_val      <= '0;
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
        end else if (i_en) begin
            r_px_data     <= i_px_data[i_sel];
            r_px_val      <= i_px_val[i_sel];
            r_line_end    <= i_line_end[i_sel];
            r_frame_start <= i_frame_start[i_sel];
            r_frame_end   <= i_frame_end[i_sel];
        end else begin
            r_px_data     <= '0;
            r_px_val      <= '0;
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
        end
    end

    assign o_px_data     = r_px_data;
    assign o_px_val      = r_px_val;
    assign o_line_end    = r_line_end;
    assign o_frame_start = r_frame_start;
    assign o_frame_end   = r_frame_end;

endmodule

// File: rtl/line_rd_ctrl.sv
// Reader-side controller for a ring of line buffers: strict ring-order pops,
// registered output stream, per-frame line count and sticky read-timeout.
module line_rd_ctrl
    import line_rd_pkg::*;
#(
    parameter int unsigned PX_WIDTH      = 12,
    parameter int unsigned PX_PER_CLK    = 4,
    parameter int unsigned MAX_LINE_SIZE = 1936,
    parameter int unsigned BUF_CNT       = 2,
    parameter int unsigned MAX_LINES     = 1096,
    parameter int unsigned TIMEOUT_SLACK = 8
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    line_rd_ctrl_if.slave  bus
);

    localparam int unsigned SEL_W    = width_of(BUF_CNT);
    localparam int unsigned CNT_W    = width_of(MAX_LINES + 1);
    localparam int unsigned WD_LIMIT = wd_limit(MAX_LINE_SIZE, PX_PER_CLK, TIMEOUT_SLACK);
    localparam int unsigned WD_W     = width_of(WD_LIMIT + 1);

    rd_state_e          r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_rd_sel, w_sel_nxt, w_sel_inc;
    logic [WD_W-1:0]    r_wd, w_wd_nxt, w_wd_inc;
    logic               r_timeout, w_timeout_nxt;
    logic [BUF_CNT-1:0] r_pop, w_pop_nxt;
    logic               r_ls_pend, w_ls_pend_nxt;
    logic               r_line_start;
    logic [CNT_W-1:0]   r_line_cnt;
    logic               r_eof_d;

    logic                                w_rd_en;
    logic                                w_any_val;
    logic                                w_ls_fire;
    logic [PX_PER_CLK-1:0][PX_WIDTH-1:0] w_px_data;
    logic [PX_PER_CLK-1:0]               w_px_val;
    logic                                w_line_end;
    logic                                w_frame_start;
    logic                                w_frame_end;

    assign w_rd_en   = (r_state == ST_READ);
    assign w_any_val = |bus.buf_px_data_val_i[r_rd_sel];
    assign w_ls_fire = w_rd_en && r_ls_pend && w_any_val;
    assign w_sel_inc = (r_rd_sel == SEL_W'(BUF_CNT - 1)) ? '0 : r_rd_sel + 1'b1;
    assign w_wd_inc  = r_wd + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_WAIT;
            r_rd_sel     <= '0;
            r_wd         <= '0;
            r_timeout    <= 1'b0;
            r_pop        <= '0;
            r_ls_pend    <= 1'b0;
            r_line_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_sel     <= w_sel_nxt;
            r_wd         <= w_wd_nxt;
            r_timeout    <= w_timeout_nxt;
            r_pop        <= w_pop_nxt;
            r_ls_pend    <= w_ls_pend_nxt;
            r_line_start <= w_ls_fire;
        end
    end

    // The pop pulse is registered on the WAIT->POP transition so it is high exactly while in POP.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_rd_sel;
        w_wd_nxt      = r_wd;
        w_timeout_nxt = r_timeout;
        w_pop_nxt     = '0;
        w_ls_pend_nxt = r_ls_pend;
        case (r_state)
            ST_WAIT: begin
                if (bus.buf_unread_i[r_rd_sel] && !bus.buf_empty_i[r_rd_sel] && bus.line_ready_i) begin
                    w_state_nxt          = ST_POP;
                    w_pop_nxt[r_rd_sel]  = 1'b1;
                end
            end
            ST_POP: begin
                w_wd_nxt      = '0;
                w_ls_pend_nxt = 1'b1;
                w_state_nxt   = ST_READ;
            end
            ST_READ: begin
                w_wd_nxt = w_wd_inc;
                if (w_any_val) begin
                    w_ls_pend_nxt = 1'b0;
                end
                if (bus.buf_line_end_i[r_rd_sel]) begin
                    w_state_nxt = ST_WAIT;
                    w_sel_nxt   = w_sel_inc;
                end else if (w_wd_inc == WD_W'(WD_LIMIT)) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_WAIT;
                    w_sel_nxt     = w_sel_inc;
                end
            end
            default: w_state_nxt = ST_WAIT;
        endcase
    end

    line_rd_mux #(
        .PX_WIDTH   (PX_WIDTH),
        .PX_PER_CLK (PX_PER_CLK),
        .BUF_CNT    (BUF_CNT)
    ) u_mux (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .i_en          (w_rd_en),
        .i_sel         (r_rd_sel),
        .i_px_data     (bus.buf_px_data_i),
        .i_px_val      (bus.buf_px_data_val_i),
        .i_line_end    (bus.buf_line_end_i),
        .i_frame_start (bus.buf_frame_start_i),
        .i_frame_end   (bus.buf_frame_end_i),
        .o_px_data     (w_px_data),
        .o_px_val      (w_px_val),
        .o_line_end    (w_line_end),
        .o_frame_start (w_frame_start),
        .o_frame_end   (w_frame_end)
    );

    // EOF clears the count one cycle after it is seen, so the final line of a frame is still counted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_line_cnt <= '0;
            r_eof_d    <= 1'b0;
        end else begin
            r_eof_d <= w_frame_end;
            if (r_eof_d) begin
                r_line_cnt <= '0;
            end else if (w_frame_start && (r_line_cnt != '0)) begin
                r_line_cnt <= '0;
            end else if (w_line_end && (r_line_cnt != CNT_W'(MAX_LINES))) begin
                r_line_cnt <= r_line_cnt + 1'b1;
            end
        end
    end

    assign bus.pop_line_o    = r_pop;
    assign bus.px_data_o     = w_px_data;
    assign bus.px_data_val_o = w_px_val;
    assign bus.line_start_o  = r_line_start;
    assign bus.line_end_o    = w_line_end;
    assign bus.frame_start_o = w_frame_start;
    assign bus.frame_end_o   = w_frame_end;
    assign bus.rd_sel_o      = r_rd_sel;
    assign bus.line_cnt_o    = r_line_cnt;
    assign bus.timeout_o     = r_timeout;

endmodule

// File: tb/tb_line_rd_ctrl.sv
// Directed self-checking bench for line_rd_ctrl with hand-computed expectations.
module tb_line_rd_ctrl;

    localparam int unsigned PXW  = 12;
    localparam int unsigned PPC  = 4;
    localparam int unsigned BUFS = 2;
    localparam int unsigned MAXL = 1096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    line_rd_ctrl_if #(.PX_WIDTH(PXW), .PX_PER_CLK(PPC), .BUF_CNT(BUFS), .MAX_LINES(MAXL)) bus ();

    line_rd_ctrl #(
        .PX_WIDTH      (PXW),
        .PX_PER_CLK    (PPC),
        .MAX_LINE_SIZE (1936),
        .BUF_CNT       (BUFS),
        .MAX_LINES     (MAXL),
        .TIMEOUT_SLACK (8)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] pattern(input int b, input int k);
        return {12'(k), 12'(b), 12'hA5A, 12'(k * 3 + 1)};
    endfunction

    task automatic clear_bufs;
        bus.buf_px_data_i     = '0;
        bus.buf_px_data_val_i = '0;
        bus.buf_line_end_i    = '0;
        bus.buf_frame_start_i = '0;
        bus.buf_frame_end_i   = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pop"},  64'(bus.pop_line_o), 64'd0);
        chk({tag, "_px"},   64'(bus.px_data_o), 64'd0);
        chk({tag, "_val"},  64'(bus.px_data_val_o), 64'd0);
        chk({tag, "_ls"},   64'(bus.line_start_o), 64'd0);
        chk({tag, "_le"},   64'(bus.line_end_o), 64'd0);
        chk({tag, "_fs"},   64'(bus.frame_start_o), 64'd0);
        chk({tag, "_fe"},   64'(bus.frame_end_o), 64'd0);
        chk({tag, "_sel"},  64'(bus.rd_sel_o), 64'd0);
        chk({tag, "_cnt"},  64'(bus.line_cnt_o), 64'd0);
        chk({tag, "_to"},   64'(bus.timeout_o), 64'd0);
    endtask

    // One full line from buffer b; the other buffer carries distractor data and flags.
    task automatic do_line(input int b, input int n, input bit fs, input bit fe);
        int o;
        o = 1 - b;
        bus.buf_unread_i[b] = 1'b1;
        bus.buf_empty_i[b]  = 1'b0;
        bus.line_ready_i    = 1'b1;
        tick;
        chk("pop", 64'(bus.pop_line_o), 64'(1 << b));
        bus.buf_unread_i[b]       = 1'b0;
        bus.buf_px_data_i[o]      = '1;
        bus.buf_px_data_val_i[o]  = '1;
        bus.buf_line_end_i[o]     = 1'b1;
        bus.buf_frame_start_i[o]  = 1'b1;
        bus.buf_frame_end_i[o]    = 1'b1;
        tick;
        chk("pop_clr", 64'(bus.pop_line_o), 64'd0);
        chk("idle_px", 64'(bus.px_data_o), 64'd0);
        for (int k = 1; k <= n; k++) begin
            bus.buf_px_data_i[b]     = pattern(b, k);
            bus.buf_px_data_val_i[b] = 4'hF;
            bus.buf_line_end_i[b]    = (k == n);
            bus.buf_frame_start_i[b] = fs && (k == 1);
            bus.buf_frame_end_i[b]   = fe && (k == n);
            tick;
            chk("px",  64'(bus.px_data_o), 64'(pattern(b, k)));
            chk("val", 64'(bus.px_data_val_o), 64'hF);
            chk("ls",  64'(bus.line_start_o), 64'(k == 1));
            chk("le",  64'(bus.line_end_o), 64'(k == n));
            chk("fs",  64'(bus.frame_start_o), 64'(fs && (k == 1)));
            chk("fe",  64'(bus.frame_end_o), 64'(fe && (k == n)));
            if (k < n) chk("sel_hold", 64'(bus.rd_sel_o), 64'(b));
        end
        clear_bufs();
        chk("sel_adv", 64'(bus.rd_sel_o), 64'(o));
    endtask

    task automatic fast_line(input int b);
        bus.buf_unread_i[b] = 1'b1;
        bus.buf_empty_i[b]  = 1'b0;
        tick;
        bus.buf_unread_i[b] = 1'b0;
        tick;
        bus.buf_px_data_val_i[b] = 4'hF;
        bus.buf_px_data_i[b]     = 48'h1;
        bus.buf_line_end_i[b]    = 1'b1;
        tick;
        clear_bufs();
    endtask

    initial begin
        bus.line_ready_i = 1'b0;
        bus.buf_empty_i  = 2'b11;
        bus.buf_unread_i = 2'b00;
        clear_bufs();

        // Reset state
        tick;
        tick;
        chk_all_zero("rst");
        rst_n = 1'b1;

        // Single 8-beat line from buffer 0, then 3-beat line from buffer 1
        do_line(0, 8, 1'b0, 1'b0);
        tick;
        chk("t1_cnt", 64'(bus.line_cnt_o), 64'd1);
        chk("t1_sel", 64'(bus.rd_sel_o), 64'd1);
        chk("t1_gated", 64'(bus.px_data_o), 64'd0);
        chk("t1_le_off", 64'(bus.line_end_o), 64'd0);
        do_line(1, 3, 1'b0, 1'b0);
        tick;
        chk("t1_cnt2", 64'(bus.line_cnt_o), 64'd2);

        // line_ready_i low blocks pops even with both buffers unread
        bus.line_ready_i = 1'b0;
        bus.buf_unread_i = 2'b11;
        bus.buf_empty_i  = 2'b00;
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("t2_nopop", 64'(bus.pop_line_o), 64'd0);
        end
        chk("t2_sel", 64'(bus.rd_sel_o), 64'd0);
        do_line(0, 4, 1'b0, 1'b0);
        do_line(1, 4, 1'b0, 1'b0);
        tick;
        chk("t2_cnt", 64'(bus.line_cnt_o), 64'd4);

        // Buffer 0 empty while buffer 1 unread: no skipping ahead
        bus.line_ready_i = 1'b1;
        bus.buf_empty_i  = 2'b01;
        bus.buf_unread_i = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("t3_nopop", 64'(bus.pop_line_o), 64'd0);
        end
        chk("t3_sel", 64'(bus.rd_sel_o), 64'd0);
        bus.buf_unread_i = 2'b00;
        bus.buf_empty_i  = 2'b11;

        // 3-line frame; SOF with a nonzero count restarts at 0, EOF clears after counting
        do_line(0, 4, 1'b1, 1'b0);
        tick;
        chk("t4_cnt1", 64'(bus.line_cnt_o), 64'd1);
        do_line(1, 4, 1'b0, 1'b0);
        tick;
        chk("t4_cnt2", 64'(bus.line_cnt_o), 64'd2);
        do_line(0, 4, 1'b0, 1'b1);
        tick;
        chk("t4_cnt3", 64'(bus.line_cnt_o), 64'd3);
        tick;
        chk("t4_cnt0", 64'(bus.line_cnt_o), 64'd0);

        // Count saturation at MAX_LINES (rd_sel is 1 here)
        for (int i = 0; i < 1096; i++) fast_line((i + 1) % 2);
        tick;
        chk("sat_full", 64'(bus.line_cnt_o), 64'd1096);
        fast_line(1);
        tick;
        chk("sat_hold", 64'(bus.line_cnt_o), 64'd1096);
        chk("sat_sel", 64'(bus.rd_sel_o), 64'd0);

        // Watchdog: 492 read cycles without line_end
        bus.buf_unread_i[0] = 1'b1;
        bus.buf_empty_i[0]  = 1'b0;
        tick;
        chk("t5_pop", 64'(bus.pop_line_o), 64'd1);
        bus.buf_unread_i[0] = 1'b0;
        tick;
        repeat (491) tick;
        chk("t5_to_early", 64'(bus.timeout_o), 64'd0);
        chk("t5_sel_hold", 64'(bus.rd_sel_o), 64'd0);
        tick;
        chk("t5_to_set", 64'(bus.timeout_o), 64'd1);
        chk("t5_sel_adv", 64'(bus.rd_sel_o), 64'd1);
        do_line(1, 2, 1'b0, 1'b0);
        chk("t5_sticky", 64'(bus.timeout_o), 64'd1);
        do_line(0, 2, 1'b0, 1'b0);
        chk("t5_sticky2", 64'(bus.timeout_o), 64'd1);

        // Asynchronous reset in the middle of a read from buffer 1
        bus.buf_unread_i[1] = 1'b1;
        bus.buf_empty_i[1]  = 1'b0;
        tick;
        chk("t6_pop", 64'(bus.pop_line_o), 64'd2);
        bus.buf_unread_i[1] = 1'b0;
        tick;
        bus.buf_px_data_i[1]     = pattern(1, 1);
        bus.buf_px_data_val_i[1] = 4'hF;
        tick;
        chk("t6_mid_px", 64'(bus.px_data_o), 64'(pattern(1, 1)));
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_async");
        clear_bufs();
        tick;
        tick;
        rst_n = 1'b1;
        bus.buf_unread_i = 2'b11;
        bus.buf_empty_i  = 2'b00;
        bus.line_ready_i = 1'b1;
        tick;
        chk("t6_pop0", 64'(bus.pop_line_o), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
